// File: rtl/alu_sequencer_if.sv
// Command and result handshakes between an upstream issuer and alu_sequencer.
// master = issuer/consumer side, slave = the sequencer.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs;
    logic [1:0] cmd_rt;
    logic       cmd_use_imm;
    logic [7:0] cmd_imm;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic [1:0] res_rd;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_rd
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_rd
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/write-back sequencer around a combinational 8-bit ALU: operand fetch from a
// 4x8 register file, one-cycle execute, result write-back and downstream handshake.
module alu_sequencer #(
    parameter int unsigned NREGS   = 4,
    parameter logic [3:0]  LOAD_OP = 4'b1111
) (
    input  logic                clk,
    input  logic                rst,
    alu_sequencer_if.slave      bus,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_opcode,
    input  logic [7:0]          alu_result,
    input  logic                alu_carry,
    output logic                flag_c
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [IDX_W-1:0]    rd_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   imm_q;

    // LOAD bypasses the ALU entirely and never produces a carry.
    logic                is_load_c;
    logic [DATA_W-1:0]   value_c;
    logic                carry_c;

    always_comb begin
        is_load_c = (op_q == LOAD_OP);
        value_c   = is_load_c ? imm_q : alu_result;
        carry_c   = is_load_c ? 1'b0 : alu_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
            bus.res_rd    <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= '0;
            flag_c        <= 1'b0;
            rd_q          <= '0;
            op_q          <= '0;
            imm_q         <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        alu_a         <= regs[bus.cmd_rs];
                        alu_b         <= bus.cmd_use_imm ? bus.cmd_imm : regs[bus.cmd_rt];
                        alu_opcode    <= bus.cmd_op;
                        rd_q          <= bus.cmd_rd;
                        op_q          <= bus.cmd_op;
                        imm_q         <= bus.cmd_imm;
                        bus.cmd_ready <= 1'b0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q]    <= value_c;
                    bus.res_data  <= value_c;
                    bus.res_carry <= carry_c;
                    bus.res_rd    <= rd_q;
                    flag_c        <= carry_c;
                    bus.res_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    // cmd_ready returns only after this edge, so no same-edge re-accept.
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU; expected values are hand-computed.
`timescale 1ns/1ps
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       flag_c;

    int vectors     = 0;
    int miscompares = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .flag_c     (flag_c)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD/SUB carry out (SUB carry = no borrow), AND/OR, else 0.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_opcode)
            4'b0000: {alu_carry, alu_result} = 9'(alu_a) + 9'(alu_b);
            4'b0001: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a >= alu_b);
            end
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge, accept it, then check EXEC and RESP timing.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic use_imm, input logic [7:0] imm);
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_rd      = rd;
        bus.cmd_rs      = rs;
        bus.cmd_rt      = rt;
        bus.cmd_use_imm = use_imm;
        bus.cmd_imm     = imm;
        check("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("cmd_ready_in_exec", 32'(bus.cmd_ready), 32'h0);
        check("res_valid_in_exec", 32'(bus.res_valid), 32'h0);
        check("alu_opcode", 32'(alu_opcode), 32'(op));
    endtask

    task automatic expect_result(input logic [7:0] data, input logic carry, input logic [1:0] rd);
        @(posedge clk);
        #1;
        check("res_valid_2_edges", 32'(bus.res_valid), 32'h1);
        check("res_data", 32'(bus.res_data), 32'(data));
        check("res_carry", 32'(bus.res_carry), 32'(carry));
        check("res_rd", 32'(bus.res_rd), 32'(rd));
        check("flag_c", 32'(flag_c), 32'(carry));
        check("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'h0);
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("res_valid_after_hs", 32'(bus.res_valid), 32'h0);
        check("cmd_ready_after_hs", 32'(bus.cmd_ready), 32'h1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 4'h0;
        bus.cmd_rd      = 2'd0;
        bus.cmd_rs      = 2'd0;
        bus.cmd_rt      = 2'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_imm     = 8'h00;
        bus.res_ready   = 1'b0;
        #12;
        check("rst_res_valid", 32'(bus.res_valid), 32'h0);
        check("rst_res_data", 32'(bus.res_data), 32'h0);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_flag_c", 32'(flag_c), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cmd_ready_out_of_rst", 32'(bus.cmd_ready), 32'h1);

        // LOAD r1 = 0x0F, LOAD r2 = 0xF1
        issue(4'b1111, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F);
        expect_result(8'h0F, 1'b0, 2'd1);
        handshake();
        issue(4'b1111, 2'd2, 2'd0, 2'd0, 1'b1, 8'hF1);
        expect_result(8'hF1, 1'b0, 2'd2);
        handshake();

        // ADD r3 = r1 + r2 = 0x0F + 0xF1 = 0x100
        issue(4'b0000, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
        check("add_alu_a", 32'(alu_a), 32'h0F);
        check("add_alu_b", 32'(alu_b), 32'hF1);
        expect_result(8'h00, 1'b1, 2'd3);
        handshake();

        // SUB both directions
        issue(4'b0001, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        expect_result(8'h1E, 1'b0, 2'd0);
        handshake();
        issue(4'b0001, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00);
        expect_result(8'hE2, 1'b1, 2'd0);
        handshake();

        // AND with immediate: 0x0F & 0x3C
        issue(4'b0010, 2'd0, 2'd1, 2'd0, 1'b1, 8'h3C);
        check("and_alu_b_imm", 32'(alu_b), 32'h3C);
        expect_result(8'h0C, 1'b0, 2'd0);
        handshake();

        // OR r1 = r1 | r2 = 0xFF
        issue(4'b0011, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00);
        expect_result(8'hFF, 1'b0, 2'd1);
        handshake();

        // r1 now 0xFF; stall the response for 5 cycles with a competing command pending
        issue(4'b0010, 2'd0, 2'd1, 2'd0, 1'b1, 8'hA5);
        check("r1_written_back", 32'(alu_a), 32'hFF);
        expect_result(8'hA5, 1'b0, 2'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'b1111;
        bus.cmd_rd    = 2'd3;
        bus.cmd_imm   = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_res_valid", 32'(bus.res_valid), 32'h1);
            check("stall_res_data", 32'(bus.res_data), 32'hA5);
            check("stall_res_rd", 32'(bus.res_rd), 32'h0);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 32'h0);
            check("stall_alu_opcode", 32'(alu_opcode), 32'h2);
        end
        bus.cmd_valid = 1'b0;
        handshake();

        // Undefined opcode 0101 writes 0 to r2
        issue(4'b0101, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00);
        expect_result(8'h00, 1'b0, 2'd2);
        handshake();
        issue(4'b0000, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
        check("r2_zeroed", 32'(alu_a), 32'h00);
        expect_result(8'hFF, 1'b0, 2'd3);
        handshake();

        // Reset during EXEC of ADD r0 = r1 + r1 (would produce 0xFE carry 1)
        issue(4'b0000, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'h0);
        check("midrst_res_data", 32'(bus.res_data), 32'h0);
        check("midrst_flag_c", 32'(flag_c), 32'h0);
        check("midrst_alu_a", 32'(alu_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);

        // Register file must be all zero: r1 + r2 = 0
        issue(4'b0000, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        check("post_rst_alu_a", 32'(alu_a), 32'h00);
        check("post_rst_alu_b", 32'(alu_b), 32'h00);
        expect_result(8'h00, 1'b0, 2'd0);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
